// File: rtl/data_sram_resp.sv
// data_sram_resp: single-port word SRAM with byte strobes and a fixed,
// programmable response latency. Each request is latched in IDLE, waits
// LATENCY cycles, performs the access, then pulses data_sram_ok once.
//
// Handshake: the requester holds data_ren (or a non-zero data_wen) until
// data_sram_ok. A request is taken only in IDLE. Once it is latched, input
// changes are ignored until the FSM returns to IDLE. data_sram_ok is high
// for exactly one cycle, in RESP.
module data_sram_resp #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_ren,
    input  logic [3:0]  data_wen,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic [1:0]  data_rsize,
    output logic [31:0] read_data,
    output logic        data_sram_ok,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEPTH = 1 << ADDR_W;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic [ADDR_W-1:0]   r_idx;
    logic [3:0]          r_wen;
    logic [31:0]         r_wdata;
    logic [31:0]         r_read_data;
    logic                r_ok;
    logic [31:0]         r_mem [DEPTH];

    logic                w_req;
    logic [ADDR_W-1:0]   w_idx;
    logic                w_mem_we;
    logic                w_unused_ok;

    // A store is any non-zero strobe; otherwise data_ren alone makes a load.
    assign w_req    = data_ren || (data_wen != 4'b0000);
    // Upper address bits alias onto the array; byte offset is dropped.
    assign w_idx    = address[ADDR_W+1:2];
    // The array is written on the final WAIT edge; reset in flight blocks it.
    assign w_mem_we = (r_state == WAIT) && (r_cnt == 4'd0) &&
                      (r_wen != 4'b0000) && !reset;
    // Load size and the ignored address bits are not used by the array.
    assign w_unused_ok = &{1'b0, data_rsize, address[1:0], address[31:ADDR_W+2]};

    assign read_data    = r_read_data;
    assign data_sram_ok = r_ok;
    assign busy         = (r_state != IDLE);

    // Control FSM: accept in IDLE, count down in WAIT, one-cycle ok in RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_idx       <= '0;
            r_wen       <= 4'b0000;
            r_wdata     <= 32'h0;
            r_read_data <= 32'h0;
            r_ok        <= 1'b0;
        end else begin
            r_ok <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_idx   <= w_idx;
                        r_wen   <= data_wen;
                        r_wdata <= write_data;
                        r_cnt   <= 4'(LATENCY);
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state <= RESP;
                        r_ok    <= 1'b1;
                        if (r_wen == 4'b0000) begin
                            r_read_data <= r_mem[r_idx];
                        end
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Storage array: no reset, only the strobed byte lanes are updated.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (r_wen[b]) begin
                    r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: directed cases plus a randomized stream against
// a word-array reference model, and a LATENCY=0 back-to-back instance.
module tb_data_sram_resp;

  localparam int LAT = 2;
  localparam int AW  = 10;

  logic        clk;
  logic        reset;
  logic        data_ren;
  logic [3:0]  data_wen;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [1:0]  data_rsize;
  logic [31:0] read_data;
  logic        data_sram_ok;
  logic        busy;

  logic        r0_ren;
  logic [3:0]  r0_wen;
  logic [31:0] r0_rdata;
  logic        r0_ok;
  logic        r0_busy;

  int checks;
  int errors;

  logic [31:0] model [0:(1<<AW)-1];
  logic [31:0] last_read;

  data_sram_resp #(.ADDR_W(AW), .LATENCY(LAT)) dut (
    .clk          (clk),
    .reset        (reset),
    .data_ren     (data_ren),
    .data_wen     (data_wen),
    .address      (address),
    .write_data   (write_data),
    .data_rsize   (data_rsize),
    .read_data    (read_data),
    .data_sram_ok (data_sram_ok),
    .busy         (busy)
  );

  data_sram_resp #(.ADDR_W(AW), .LATENCY(0)) dut0 (
    .clk          (clk),
    .reset        (reset),
    .data_ren     (r0_ren),
    .data_wen     (r0_wen),
    .address      (32'h0000_0008),
    .write_data   (32'h0),
    .data_rsize   (2'd2),
    .read_data    (r0_rdata),
    .data_sram_ok (r0_ok),
    .busy         (r0_busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr / 4) % (1 << AW));
  endfunction

  // One complete transaction on the LATENCY=2 instance with cycle-by-cycle
  // checks of busy/ok; optionally drops the request right after acceptance.
  task automatic txn(input bit is_wr, input logic [31:0] addr, input logic [3:0] wen,
                     input logic [31:0] wdata, input bit flush, input string tag);
    int idx;
    logic [31:0] exp_rd;
    idx = word_of(addr);
    address    = addr;
    write_data = wdata;
    data_rsize = 2'($urandom_range(0, 2));
    if (is_wr) begin
      data_wen = wen;
      data_ren = 1'($urandom_range(0, 1));
    end else begin
      data_wen = 4'b0000;
      data_ren = 1'b1;
    end
    for (int n = 1; n <= LAT + 2; n++) begin
      @(posedge clk); #1;
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "_ok"}, {31'd0, data_sram_ok}, {31'd0, (n == LAT + 2)});
      if (flush && n == 1) begin
        data_ren   = 1'b0;
        data_wen   = 4'b0000;
        address    = $urandom;
        write_data = $urandom;
      end
    end
    if (is_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wen[b]) model[idx][8*b +: 8] = wdata[8*b +: 8];
      end
      exp_rd = last_read;
    end else begin
      exp_rd    = model[idx];
      last_read = exp_rd;
    end
    chk({tag, "_rdata"}, read_data, exp_rd);
    data_ren = 1'b0;
    data_wen = 4'b0000;
    @(posedge clk); #1;
    chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_idle_ok"}, {31'd0, data_sram_ok}, 32'd0);
  endtask

  initial begin
    int kind;
    logic [31:0] a;
    checks = 0;
    errors = 0;
    last_read  = 32'h0;
    reset      = 1'b1;
    data_ren   = 1'b0;
    data_wen   = 4'b0000;
    address    = 32'h0;
    write_data = 32'h0;
    data_rsize = 2'd0;
    r0_ren     = 1'b0;
    r0_wen     = 4'b0000;
    for (int i = 0; i < (1 << AW); i++) model[i] = 32'h0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ok", {31'd0, data_sram_ok}, 32'd0);
    chk("rst_rdata", read_data, 32'h0);
    reset = 1'b0;

    // write then read
    txn(1'b1, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, 1'b0, "wr10");
    txn(1'b0, 32'h0000_0010, 4'b0000, 32'h0, 1'b0, "rd10");
    chk("rd10_const", read_data, 32'hDEAD_BEEF);

    // byte strobes, offset ignored
    txn(1'b1, 32'h0000_0020, 4'b1111, 32'h1122_3344, 1'b0, "wr20");
    txn(1'b1, 32'h0000_0020, 4'b0100, 32'h00AA_0000, 1'b0, "wr20b");
    txn(1'b0, 32'h0000_0023, 4'b0000, 32'h0, 1'b0, "rd23");
    chk("rd23_const", read_data, 32'h11AA_3344);

    // upper address bits alias
    txn(1'b1, 32'h0000_1004, 4'b1111, 32'h0000_0055, 1'b0, "wr1004");
    txn(1'b0, 32'h0000_0004, 4'b0000, 32'h0, 1'b0, "rd04");
    chk("rd04_const", read_data, 32'h0000_0055);

    // request dropped during WAIT still completes
    txn(1'b1, 32'h0000_000C, 4'b1111, 32'h1234_5678, 1'b1, "flush");
    txn(1'b0, 32'h0000_000C, 4'b0000, 32'h0, 1'b0, "rd0c");
    chk("rd0c_const", read_data, 32'h1234_5678);

    // reset during WAIT of a write: no array update, outputs clear at once
    txn(1'b1, 32'h0000_0040, 4'b1111, 32'h0, 1'b0, "wr40z");
    txn(1'b0, 32'h0000_0010, 4'b0000, 32'h0, 1'b0, "rd10b");
    address    = 32'h0000_0040;
    write_data = 32'hCAFE_F00D;
    data_wen   = 4'b1111;
    data_ren   = 1'b0;
    @(posedge clk); #1;
    chk("rstw_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rstw_busy", {31'd0, busy}, 32'd0);
    chk("rstw_ok", {31'd0, data_sram_ok}, 32'd0);
    chk("rstw_rdata", read_data, 32'h0);
    #1;
    reset     = 1'b0;
    data_wen  = 4'b0000;
    last_read = 32'h0;
    txn(1'b0, 32'h0000_0040, 4'b0000, 32'h0, 1'b0, "rd40");
    chk("rd40_const", read_data, 32'h0);

    // randomized stream over 16 words with aliasing upper bits
    for (int w = 0; w < 16; w++) begin
      txn(1'b1, 32'(w * 4), 4'b1111, $urandom, 1'b0, "rinit");
    end
    for (int t = 0; t < 40; t++) begin
      kind = int'($urandom_range(0, 1));
      a = {$urandom_range(0, 255) << 12} | 32'($urandom_range(0, 15) * 4)
          | 32'($urandom_range(0, 3));
      if (kind == 1) begin
        txn(1'b1, a, 4'($urandom_range(1, 15)), $urandom, 1'($urandom_range(0, 1)), "rwr");
      end else begin
        txn(1'b0, a, 4'b0000, 32'h0, 1'($urandom_range(0, 1)), "rrd");
      end
    end

    // LATENCY=0: read held continuously -> ok every 3 cycles, 1 wide
    @(posedge clk); #1;
    r0_ren = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      @(posedge clk); #1;
      chk("l0_ok", {31'd0, r0_ok}, {31'd0, (n % 3 == 2)});
      chk("l0_busy", {31'd0, r0_busy}, {31'd0, (n % 3 != 0)});
    end
    r0_ren = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("l0_done", {31'd0, r0_busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
